mmio_uart_tx: RTL and testbench



---
 rtl/mmio_uart_tx.sv | 164 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: CPU-writable TX FIFO feeding an 8N1 serialiser on the tx pin.
module mmio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 200,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        uartclk,
    input  logic        uartrst,
    input  logic        uartcs,
    input  logic        uartwrite,
    input  logic        uartread,
    input  logic [1:0]  uartaddr,
    input  logic [7:0]  uartwdata,
    output logic [15:0] uartrdata,
    output logic        tx
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                overflow_q;
    logic [7:0]          shift_q, shift_d;
    logic [2:0]          bit_q, bit_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic                tx_d;

    logic empty_c, full_c, busy_c;
    logic data_wr_c, ctrl_wr_c, push_c, pop_c, baud_end_c;

    assign empty_c    = (count_q == '0);
    assign full_c     = (count_q == DEPTH_CNT);
    assign busy_c     = (state_q != ST_IDLE);
    assign data_wr_c  = uartcs & uartwrite & (uartaddr == 2'b00);
    assign ctrl_wr_c  = uartcs & uartwrite & (uartaddr == 2'b10);
    // Full is judged before any same-edge pop, so a write while full is always dropped.
    assign push_c     = data_wr_c & ~full_c;
    assign baud_end_c = (baud_q == BAUD_LAST);

    // Next-state, shifter and bit-timing logic for the serialiser.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        pop_c   = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (!empty_c) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_mem[rd_ptr_q];
                    bit_d   = '0;
                    baud_d  = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                baud_d = baud_end_c ? '0 : baud_q + BAUD_W'(1);
                if (baud_end_c) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                baud_d = baud_end_c ? '0 : baud_q + BAUD_W'(1);
                if (baud_end_c) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                baud_d = baud_end_c ? '0 : baud_q + BAUD_W'(1);
                if (baud_end_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // tx is registered from the level the next state will drive.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // Serialiser state and registered tx pin.
    always_ff @(posedge uartclk) begin
        if (uartrst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
            tx      <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            tx      <= tx_d;
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge uartclk) begin
        if (push_c) begin
            fifo_mem[wr_ptr_q] <= uartwdata;
        end
    end

    // FIFO pointers, fill level and sticky overflow flag.
    always_ff @(posedge uartclk) begin
        if (uartrst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (data_wr_c && full_c) begin
                overflow_q <= 1'b1;
            end else if (ctrl_wr_c && uartwdata[0]) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Registered read bus; holds its value when no read is strobed.
    always_ff @(posedge uartclk) begin
        if (uartrst) begin
            uartrdata <= '0;
        end else if (uartcs && uartread) begin
            case (uartaddr)
                2'b00:   uartrdata <= 16'(count_q);
                2'b10:   uartrdata <= {12'b0, overflow_q, empty_c, full_c, busy_c};
                default: uartrdata <= 16'h0000;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench with a byte scoreboard and serial-frame monitor.
module tb_mmio_uart_tx;
    localparam int unsigned CPB       = 4;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned FRAME_LEN = 10 * CPB;

    logic        uartclk;
    logic        uartrst;
    logic        uartcs;
    logic        uartwrite;
    logic        uartread;
    logic [1:0]  uartaddr;
    logic [7:0]  uartwdata;
    logic [15:0] uartrdata;
    logic        tx;

    mmio_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .uartclk  (uartclk),
        .uartrst  (uartrst),
        .uartcs   (uartcs),
        .uartwrite(uartwrite),
        .uartread (uartread),
        .uartaddr (uartaddr),
        .uartwdata(uartwdata),
        .uartrdata(uartrdata),
        .tx       (tx)
    );

    initial uartclk = 1'b0;
    always #5 uartclk = ~uartclk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q [$];
    int         start_q [$];
    int         cyc = 0;
    int         frames_done = 0;
    bit         mon_abort = 1'b0;
    bit         mon_active = 1'b0;
    int         mon_k = 0;
    logic [FRAME_LEN-1:0] mon_wave;
    logic [FRAME_LEN-1:0] mon_exp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Ideal 8N1 waveform, one sample per clock, LSB first.
    function automatic logic [FRAME_LEN-1:0] frame_wave(input logic [7:0] b);
        logic [FRAME_LEN-1:0] w;
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < int'(FRAME_LEN); k++) w[k] = bits[k / int'(CPB)];
        return w;
    endfunction

    // Frame monitor: captures every frame on tx and compares it to the scoreboard head.
    always @(negedge uartclk) begin
        cyc++;
        if (mon_abort) begin
            mon_active = 1'b0;
        end else if (mon_active) begin
            mon_wave[mon_k] = tx;
            mon_k++;
            if (mon_k == int'(FRAME_LEN)) begin
                chk("frame", 64'(mon_wave), 64'(mon_exp));
                frames_done++;
                mon_active = 1'b0;
            end
        end else if (tx === 1'b0) begin
            chk("start_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) mon_exp = frame_wave(exp_q.pop_front());
            else mon_exp = '0;
            start_q.push_back(cyc);
            mon_wave    = '0;
            mon_wave[0] = tx;
            mon_k       = 1;
            mon_active  = 1'b1;
        end
    end

    task automatic tick();
        @(posedge uartclk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        uartcs = 1'b1; uartwrite = 1'b1; uartaddr = a; uartwdata = d;
        tick();
        uartcs = 1'b0; uartwrite = 1'b0; uartaddr = 2'b00; uartwdata = 8'h00;
    endtask

    task automatic wr_data(input logic [7:0] d, input bit accept);
        if (accept) exp_q.push_back(d);
        wr(2'b00, d);
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] d);
        uartcs = 1'b1; uartread = 1'b1; uartaddr = a;
        tick();
        d = uartrdata;
        uartcs = 1'b0; uartread = 1'b0; uartaddr = 2'b00;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [15:0] exp, input string tag);
        logic [15:0] d;
        rd(a, d);
        chk(tag, 64'(d), 64'(exp));
    endtask

    task automatic wait_status(input logic [15:0] exp, input string tag);
        logic [15:0] d;
        int n;
        n = 0;
        do begin
            rd(2'b10, d);
            n++;
        end while (d !== exp && n < 3000);
        chk(tag, 64'(d), 64'(exp));
    endtask

    task automatic check_gaps(input int nframes, input string tag);
        chk({tag, "_frames"}, 64'(start_q.size()), 64'(nframes));
        for (int i = 1; i < start_q.size(); i++)
            chk({tag, "_gap"}, 64'(start_q[i] - start_q[i-1]), 64'(FRAME_LEN + 1));
    endtask

    task automatic tx_high_window(input int n, input string tag);
        logic all_high;
        all_high = 1'b1;
        repeat (n) begin
            tick();
            all_high = all_high & tx;
        end
        chk(tag, 64'(all_high), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] b10 [10];
    logic [15:0] rv;

    initial begin
        uartrst = 1'b1; uartcs = 1'b0; uartwrite = 1'b0; uartread = 1'b0;
        uartaddr = 2'b00; uartwdata = 8'h00;
        tick(); tick();
        uartrst = 1'b0;

        // Reset state
        chk("reset_tx", 64'(tx), 64'd1);
        chk("reset_rdata", 64'(uartrdata), 64'h0);
        rd_chk(2'b10, 16'h0004, "reset_status");
        rd_chk(2'b00, 16'h0000, "reset_count");

        // Single byte A5: exact pop latency and busy duration
        wr_data(8'hA5, 1'b1);
        chk("a5_tx_before_pop", 64'(tx), 64'd1);
        tick();
        chk("a5_tx_fall", 64'(tx), 64'd0);
        rd_chk(2'b10, 16'h0005, "a5_status_busy");
        repeat (38) tick();
        rd_chk(2'b10, 16'h0005, "a5_busy_last");
        rd_chk(2'b10, 16'h0004, "a5_idle_after");

        // Ten back-to-back writes: overflow on the tenth
        b10 = '{8'h3C, 8'hC3, 8'h00, 8'hFF, 8'h81, 8'h7E, 8'h55, 8'hAA, 8'h12, 8'h99};
        start_q.delete();
        for (int i = 0; i < 10; i++) begin
            wr_data(b10[i], i < 9);
            if (i == 1) chk("burst_b0_popped", 64'(tx), 64'd0);
        end
        rd_chk(2'b10, 16'h000B, "burst_status_full");
        rd_chk(2'b00, 16'h0008, "burst_count_full");
        wait_status(16'h000C, "burst_drained");
        check_gaps(9, "burst");
        chk("burst_sb_empty", 64'(exp_q.size()), 64'd0);
        wr(2'b10, 8'hFE);
        rd_chk(2'b10, 16'h000C, "ovf_kept_bit0_low");
        wr(2'b10, 8'h01);
        rd_chk(2'b10, 16'h0004, "ovf_cleared");
        rd_chk(2'b00, 16'h0000, "drained_count");

        // Reset during data bit 3 with three bytes queued
        wr_data(8'h5A, 1'b1);
        wr_data(8'h11, 1'b1);
        wr_data(8'h22, 1'b1);
        wr_data(8'h33, 1'b1);
        repeat (15) tick();
        mon_abort = 1'b1;
        uartrst   = 1'b1;
        tick();
        uartrst   = 1'b0;
        chk("rst_mid_tx", 64'(tx), 64'd1);
        chk("rst_mid_rdata", 64'(uartrdata), 64'h0);
        exp_q.delete();
        mon_abort = 1'b0;
        rd_chk(2'b10, 16'h0004, "rst_mid_status");
        rd_chk(2'b00, 16'h0000, "rst_mid_count");
        tx_high_window(60, "rst_no_restart");

        // Ignored writes and read-hold behaviour
        uartcs = 1'b0; uartwrite = 1'b1; uartaddr = 2'b00; uartwdata = 8'h77;
        tick();
        uartwrite = 1'b0;
        wr(2'b01, 8'h44);
        wr(2'b11, 8'h45);
        rd_chk(2'b00, 16'h0000, "ignored_wr_count");
        tx_high_window(12, "ignored_wr_tx");
        rd_chk(2'b10, 16'h0004, "hold_setup");
        uartcs = 1'b1; uartread = 1'b0; uartaddr = 2'b00;
        tick(); tick();
        chk("hold_no_read", 64'(uartrdata), 64'h0004);
        uartcs = 1'b0; uartread = 1'b1;
        tick();
        uartread = 1'b0;
        chk("hold_no_cs", 64'(uartrdata), 64'h0004);
        rd_chk(2'b01, 16'h0000, "rd_addr01");
        rd_chk(2'b10, 16'h0004, "rd_status_again");
        rd_chk(2'b11, 16'h0000, "rd_addr11");

        // Push coinciding with pop at count 3; twenty bytes across pointer wrap
        start_q.delete();
        frames_done = 0;
        for (int i = 0; i < 4; i++) wr_data(8'(i * 37 + 5), 1'b1);
        rd_chk(2'b00, 16'h0003, "pp_count_initial");
        repeat (37) tick();
        for (int m = 0; m < 16; m++) begin
            wr_data(8'((m + 4) * 37 + 5), 1'b1);
            rd_chk(2'b00, 16'h0003, "pp_count_same");
            repeat (39) tick();
        end
        wait_status(16'h0004, "pp_drained");
        check_gaps(20, "pp");
        chk("pp_frames_done", 64'(frames_done), 64'd20);
        chk("pp_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
